mem_frame_serializer: RTL

//   Takes one 2-D unpacked array frame of WIDTH-bit words and streams it out, one word per beat.

---
 rtl/mem_frame_serializer_if.sv | 30 +++
 rtl/mem_frame_serializer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_frame_serializer_if.sv
// Frame-in / word-stream-out bundle for mem_frame_serializer.
// master = frame source and beat sink; slave = the serializer itself.
interface mem_frame_serializer_if #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4,
  parameter int COLS  = 5
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_frame [ROWS-1:0][COLS-1:0];
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [RW-1:0]    out_row;
  logic [CW-1:0]    out_col;
  logic             out_last;

  modport master (
    output in_valid, in_frame, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last
  );

  modport slave (
    input  in_valid, in_frame, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last
  );
endinterface

// File: rtl/mem_frame_serializer.sv
// Captures one ROWS x COLS frame and streams it row-major, one word per valid/ready beat.
// Defining MEM_SERIAL_CSUM_EN appends a modulo-2^WIDTH checksum beat after the data beats.
module mem_frame_serializer #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4,
  parameter int COLS  = 5
) (
  input logic                   clk,
  input logic                   rst,
  mem_frame_serializer_if.slave bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

`ifdef MEM_SERIAL_CSUM_EN
  typedef enum logic [1:0] {IDLE, STREAM, CSUM} state_t;
`else
  typedef enum logic {IDLE, STREAM} state_t;
`endif

  state_t           state, state_nxt;
  logic [RW-1:0]    row, row_nxt;
  logic [CW-1:0]    col, col_nxt;
  logic             capture;
  logic             accept;
  logic             at_end;
  logic [WIDTH-1:0] frame_buf [ROWS-1:0][COLS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
    end
  end

  // Buffer contents are irrelevant until a capture, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          frame_buf[r][c] <= bus.in_frame[r][c];
        end
      end
    end
  end

`ifdef MEM_SERIAL_CSUM_EN
  logic [WIDTH-1:0] csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (capture) begin
      csum <= '0;
    end else if (accept) begin
      csum <= csum + bus.out_data;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    capture   = 1'b0;
    accept    = 1'b0;
    at_end    = (row == ROW_MAX) && (col == COL_MAX);

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          capture   = 1'b1;
          state_nxt = STREAM;
          row_nxt   = '0;
          col_nxt   = '0;
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          accept = 1'b1;
          if (at_end) begin
            row_nxt = '0;
            col_nxt = '0;
`ifdef MEM_SERIAL_CSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = IDLE;
`endif
          end else if (col == COL_MAX) begin
            col_nxt = '0;
            row_nxt = row + 1'b1;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
`ifdef MEM_SERIAL_CSUM_EN
      CSUM: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state != IDLE);
    bus.out_row   = row;
    bus.out_col   = col;
    bus.out_data  = '0;
    if (state == STREAM) begin
      bus.out_data = frame_buf[row][col];
    end
`ifdef MEM_SERIAL_CSUM_EN
    if (state == CSUM) begin
      bus.out_data = csum;
    end
    bus.out_last = (state == CSUM);
`else
    bus.out_last = (state == STREAM) && at_end;
`endif
  end
endmodule
